ram_arbiter: RTL

- Sequences the single shared SDRAM byte port (sram) among four requesters: ROM/file download (ioctl), smart_tape buffer reads, FDD buffer reads and the CPU/divmmc memory path.
- Replaces the fixed combinational address/data mux with a registered request/acknowledge scheduler.
- Holds each access stable for a fixed number of cycles, then returns read data with a one-cycle ack.
- Sits between the requesters and sram; runs on clk_sys.

---
 rtl/ram_arb_pkg.sv | 37 +++
 rtl/ram_arbiter_if.sv | 29 ++
 rtl/ram_arb_pick.sv | 64 ++++++
 rtl/ram_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared definitions for the SDRAM byte-port arbiter.
//   NPORTS          number of requesters
//   PORT_*          requester indices (ioctl, tape, fdd, cpu)
//   arb_state_t     scheduler states
//   next_port()     round-robin successor among ports 1..3
//   port_onehot()   port index to one-hot ack vector
package ram_arb_pkg;

   localparam int NPORTS = 4;

   localparam logic [1:0] PORT_IOCTL = 2'd0;
   localparam logic [1:0] PORT_TAPE  = 2'd1;
   localparam logic [1:0] PORT_FDD   = 2'd2;
   localparam logic [1:0] PORT_CPU   = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } arb_state_t;

   // Successor in the 1 -> 2 -> 3 -> 1 rotation; anything else restarts at 1.
   function automatic logic [1:0] next_port(input logic [1:0] p);
      logic [1:0] n;
      case (p)
         2'd1:    n = 2'd2;
         2'd2:    n = 2'd3;
         default: n = 2'd1;
      endcase
      return n;
   endfunction

   function automatic logic [NPORTS-1:0] port_onehot(input logic [1:0] p);
      return {{(NPORTS-1){1'b0}}, 1'b1} << p;
   endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester-side bundle of the SDRAM arbiter.
//   req/req_we       per-port level request and write qualifier
//   req_addr/req_din per-port address and write data, port i at [i*W +: W]
//   ack              one-cycle completion pulse per port
//   rdata            read data, valid in the ack cycle and held afterwards
// Modports: master = requesters, slave = arbiter.
interface ram_arbiter_if
   import ram_arb_pkg::*;
#(
   parameter int AW = 25,
   parameter int DW = 8
);
   logic [NPORTS-1:0]    req;
   logic [NPORTS-1:0]    req_we;
   logic [NPORTS*AW-1:0] req_addr;
   logic [NPORTS*DW-1:0] req_din;
   logic [NPORTS-1:0]    ack;
   logic [DW-1:0]        rdata;

   modport master (
      output req, req_we, req_addr, req_din,
      input  ack, rdata
   );

   modport slave (
      input  req, req_we, req_addr, req_din,
      output ack, rdata
   );
endinterface

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational winner selection for the SDRAM arbiter.
//   req     pending requests, bit 0 ioctl .. bit 3 cpu
//   ptr     round-robin start port (1..3)
//   winner  index of the selected port
//   valid   at least one request pending
// Port 0 always wins. With RAM_ARB_ROUND_ROBIN_EN defined, ports 1..3 are
// scanned starting at ptr; otherwise they use fixed priority 1 > 2 > 3 and
// ptr is ignored.
module ram_arb_pick
   import ram_arb_pkg::*;
(
   input  logic [NPORTS-1:0] req,
   input  logic [1:0]        ptr,
   output logic [1:0]        winner,
   output logic              valid
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
   logic [1:0] cand_s;
   logic       found_s;

   // Priority select: ioctl first, then a rotating scan of ports 1..3.
   always_comb begin
      valid   = |req;
      winner  = PORT_IOCTL;
      cand_s  = ptr;
      found_s = 1'b0;
      if (req[PORT_IOCTL]) begin
         winner = PORT_IOCTL;
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (!found_s && req[cand_s]) begin
               winner  = cand_s;
               found_s = 1'b1;
            end else begin
               found_s = found_s;
            end
            cand_s = next_port(cand_s);
         end
      end
   end
`else
   logic unused_ptr_s;
   assign unused_ptr_s = ^ptr;

   // Priority select: ioctl first, then fixed tape > fdd > cpu.
   always_comb begin
      valid  = |req;
      winner = PORT_IOCTL;
      if (req[PORT_IOCTL]) begin
         winner = PORT_IOCTL;
      end else if (req[PORT_TAPE]) begin
         winner = PORT_TAPE;
      end else if (req[PORT_FDD]) begin
         winner = PORT_FDD;
      end else if (req[PORT_CPU]) begin
         winner = PORT_CPU;
      end else begin
         winner = PORT_IOCTL;
      end
   end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: registered request/acknowledge scheduler for the shared SDRAM
// byte port (ioctl, tape, fdd, cpu requesters).
//   clk_sys, reset_n     clock and asynchronous active-low reset
//   bus (slave)          requester bundle: req/req_we/req_addr/req_din in,
//                        ack/rdata out
//   ram_addr/ram_din     address and write data to sram
//   ram_we/ram_rd        strobes, held ACCESS_CYCLES cycles per access
//   ram_dout             read data from sram
//   busy                 high while an access is in ACCESS or DONE
//   grant_id             port being served, holds last value while idle
// Optional macro RAM_ARB_ROUND_ROBIN_EN: round-robin among ports 1..3
// (default build: fixed priority 1 > 2 > 3). Port 0 always has priority.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int AW            = 25,
   parameter int DW            = 8,
   parameter int ACCESS_CYCLES = 4
)(
   input  logic          clk_sys,
   input  logic          reset_n,
   ram_arbiter_if.slave  bus,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   output logic          ram_we,
   output logic          ram_rd,
   input  logic [DW-1:0] ram_dout,
   output logic          busy,
   output logic [1:0]    grant_id
);

   localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

   arb_state_t        state_r, next_state_s;
   logic [3:0]        cnt_r, cnt_s;
   logic [1:0]        ptr_s, win_s, grant_r, grant_s;
   logic              win_vld_s;
   logic [AW-1:0]     ram_addr_r, ram_addr_s, sel_addr_s;
   logic [DW-1:0]     ram_din_r, ram_din_s, sel_din_s;
   logic              ram_we_r, ram_we_s, ram_rd_r, ram_rd_s;
   logic [DW-1:0]     rdata_r, rdata_s;
   logic [NPORTS-1:0] ack_r, ack_s;
   logic              busy_r, busy_s;

   ram_arb_pick u_pick (
      .req    (bus.req),
      .ptr    (ptr_s),
      .winner (win_s),
      .valid  (win_vld_s)
   );

`ifdef RAM_ARB_ROUND_ROBIN_EN
   logic [1:0] ptr_r;

   // Round-robin pointer: advances past each served port 1..3, ioctl leaves it.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         ptr_r <= PORT_TAPE;
      end else if ((state_r == IDLE) && win_vld_s && (win_s != PORT_IOCTL)) begin
         ptr_r <= next_port(win_s);
      end else begin
         ptr_r <= ptr_r;
      end
   end

   assign ptr_s = ptr_r;
`else
   assign ptr_s = PORT_TAPE;
`endif

   assign sel_addr_s = bus.req_addr[int'(win_s)*AW +: AW];
   assign sel_din_s  = bus.req_din[int'(win_s)*DW +: DW];

   // State register.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic; the counter is only reloaded from IDLE so it never wraps.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (win_vld_s) begin
               next_state_s = ACCESS;
            end else begin
               next_state_s = IDLE;
            end
         end
         ACCESS: begin
            if (cnt_r == 4'd0) begin
               next_state_s = DONE;
            end else begin
               next_state_s = ACCESS;
            end
         end
         DONE:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // Output logic: next values of all registered outputs and the counter.
   always_comb begin
      ram_addr_s = ram_addr_r;
      ram_din_s  = ram_din_r;
      ram_we_s   = ram_we_r;
      ram_rd_s   = ram_rd_r;
      grant_s    = grant_r;
      rdata_s    = rdata_r;
      cnt_s      = cnt_r;
      ack_s      = '0;
      busy_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (win_vld_s) begin
               grant_s    = win_s;
               ram_addr_s = sel_addr_s;
               ram_we_s   = bus.req_we[win_s];
               ram_rd_s   = ~bus.req_we[win_s];
               cnt_s      = CNT_LOAD;
               busy_s     = 1'b1;
               if (bus.req_we[win_s]) begin
                  ram_din_s = sel_din_s;
               end else begin
                  ram_din_s = ram_din_r;
               end
            end else begin
               ram_we_s = 1'b0;
               ram_rd_s = 1'b0;
            end
         end
         ACCESS: begin
            busy_s = 1'b1;
            if (cnt_r == 4'd0) begin
               // Last strobe cycle: sample sram and raise ack for the DONE cycle.
               if (ram_rd_r) begin
                  rdata_s = ram_dout;
               end else begin
                  rdata_s = rdata_r;
               end
               ram_we_s = 1'b0;
               ram_rd_s = 1'b0;
               ack_s    = port_onehot(grant_r);
            end else begin
               cnt_s = cnt_r - 4'd1;
            end
         end
         DONE: begin
            busy_s = 1'b0;
         end
         default: begin
            ram_we_s = 1'b0;
            ram_rd_s = 1'b0;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         ram_addr_r <= '0;
         ram_din_r  <= '0;
         ram_we_r   <= 1'b0;
         ram_rd_r   <= 1'b0;
         grant_r    <= 2'd0;
         rdata_r    <= '0;
         cnt_r      <= 4'd0;
         ack_r      <= '0;
         busy_r     <= 1'b0;
      end else begin
         ram_addr_r <= ram_addr_s;
         ram_din_r  <= ram_din_s;
         ram_we_r   <= ram_we_s;
         ram_rd_r   <= ram_rd_s;
         grant_r    <= grant_s;
         rdata_r    <= rdata_s;
         cnt_r      <= cnt_s;
         ack_r      <= ack_s;
         busy_r     <= busy_s;
      end
   end

   assign ram_addr  = ram_addr_r;
   assign ram_din   = ram_din_r;
   assign ram_we    = ram_we_r;
   assign ram_rd    = ram_rd_r;
   assign grant_id  = grant_r;
   assign busy      = busy_r;
   assign bus.ack   = ack_r;
   assign bus.rdata = rdata_r;

endmodule
